// File: rtl/cacheline_burst_adaptor_if.sv
// Line-side (cache) and burst-side (memory) signal bundle for cacheline_burst_adaptor.
// The adaptor uses the slave modport; the cache/memory environment uses master.
interface cacheline_burst_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [31:0]            pmem_address;
  logic                   pmem_read;
  logic                   pmem_write;
  logic [LINE_WIDTH-1:0]  pmem_wdata;
  logic [LINE_WIDTH-1:0]  pmem_rdata;
  logic                   pmem_resp;
  logic [31:0]            burst_address;
  logic                   burst_read;
  logic                   burst_write;
  logic [BURST_WIDTH-1:0] burst_wdata;
  logic [BURST_WIDTH-1:0] burst_rdata;
  logic                   burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts whole-line cache read/write requests into fixed-length bursts of narrow beats.
// Optional line transaction counters: define CACHELINE_ADAPTOR_PERF_CNT_EN.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  cacheline_burst_adaptor_if.slave  bus
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  ,
  input  logic                      perf_clr,
  output logic [31:0]               line_reads_o,
  output logic [31:0]               line_writes_o
`endif
);

  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2,
    DONE        = 2'd3
  } state_t;

  state_t                              state;
  state_t                              state_next;
  logic [CNT_W-1:0]                    count;
  logic [31:0]                         addr;
  logic [BEATS-1:0][BURST_WIDTH-1:0]   wline;
  logic [BEATS-1:0][BURST_WIDTH-1:0]   rline;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; outputs come straight from registered state/data
  always_comb begin
    state_next        = state;
    bus.burst_read    = 1'b0;
    bus.burst_write   = 1'b0;
    bus.pmem_resp     = 1'b0;
    bus.burst_address = addr;
    bus.burst_wdata   = wline[count];
    bus.pmem_rdata    = rline;
    case (state)
      IDLE: begin
        if (bus.pmem_write) begin
          state_next = WRITE_BURST;
        end else if (bus.pmem_read) begin
          state_next = READ_BURST;
        end else begin
          state_next = IDLE;
        end
      end
      READ_BURST: begin
        bus.burst_read = 1'b1;
        if (bus.burst_resp && (count == LAST_BEAT)) begin
          state_next = DONE;
        end else begin
          state_next = READ_BURST;
        end
      end
      WRITE_BURST: begin
        bus.burst_write = 1'b1;
        if (bus.burst_resp && (count == LAST_BEAT)) begin
          state_next = DONE;
        end else begin
          state_next = WRITE_BURST;
        end
      end
      DONE: begin
        bus.pmem_resp = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and read-line assembly; the counter parks on
  // the last beat so it only restarts on a new transaction or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      addr  <= 32'd0;
      wline <= '0;
      rline <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pmem_write) begin
            addr  <= {bus.pmem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            wline <= bus.pmem_wdata;
            count <= '0;
          end else if (bus.pmem_read) begin
            addr  <= {bus.pmem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            count <= '0;
          end
        end
        READ_BURST: begin
          if (bus.burst_resp) begin
            rline[count] <= bus.burst_rdata;
            if (count != LAST_BEAT) begin
              count <= count + CNT_W'(1);
            end
          end
        end
        WRITE_BURST: begin
          if (bus.burst_resp && (count != LAST_BEAT)) begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic is_write;

  // Remember the transaction type so DONE can bump the right counter
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write <= 1'b0;
    end else if (state == IDLE) begin
      is_write <= bus.pmem_write;
    end
  end

  // Saturating line counters; clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      line_reads_o  <= 32'd0;
      line_writes_o <= 32'd0;
    end else if (state == DONE) begin
      if (is_write) begin
        if (line_writes_o != 32'hFFFF_FFFF) begin
          line_writes_o <= line_writes_o + 32'd1;
        end
      end else begin
        if (line_reads_o != 32'hFFFF_FFFF) begin
          line_reads_o <= line_reads_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench: directed scenarios plus randomized line traffic against a
// line-granular memory model keyed by aligned address.
module tb_cacheline_burst_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus ();

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] line_reads;
  logic [31:0] line_writes;
`endif

  cacheline_burst_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    ,
    .perf_clr(perf_clr),
    .line_reads_o(line_reads),
    .line_writes_o(line_writes)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt_rd = 0;
  int cnt_wr = 0;
  logic [LW-1:0] mem [logic [31:0]];
  logic [LW-1:0] last_rd;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // One line transaction; returns in its pmem_resp cycle with the request still held.
  task automatic xfer(input bit wr, input bit both, input logic [31:0] addr,
                      input logic [LW-1:0] wl, input int smin, input int smax,
                      input bit from_done);
    logic [31:0]   al;
    logic [LW-1:0] exp_line;
    al = addr & ~32'(LW / 8 - 1);
    bus.pmem_address = addr;
    bus.pmem_write   = wr;
    bus.pmem_read    = !wr || both;
    bus.pmem_wdata   = wl;
    if (from_done) begin
      @(posedge clk); #1;
      chk("gap_pmem_resp", LW'(bus.pmem_resp), LW'(1'b0));
      chk("gap_busy", LW'({bus.burst_read, bus.burst_write}), LW'(2'b00));
    end
    exp_line = mem.exists(al) ? mem[al] : rnd_line();
    @(posedge clk); #1;
    bus.pmem_address = $urandom;
    for (int b = 0; b < NB; b++) begin
      int st;
      st = $urandom_range(smax, smin);
      for (int s = 0; s <= st; s++) begin
        bus.burst_resp  = (s == st);
        bus.burst_rdata = (s == st) ? exp_line[b*BW +: BW] : {$urandom, $urandom};
        chk("burst_address", LW'(bus.burst_address), LW'(al));
        chk("burst_read", LW'(bus.burst_read), LW'(!wr));
        chk("burst_write", LW'(bus.burst_write), LW'(wr));
        chk("early_pmem_resp", LW'(bus.pmem_resp), LW'(1'b0));
        if (wr) chk("burst_wdata", LW'(bus.burst_wdata), LW'(wl[b*BW +: BW]));
        @(posedge clk); #1;
      end
    end
    bus.burst_resp = 1'b0;
    chk("pmem_resp", LW'(bus.pmem_resp), LW'(1'b1));
    chk("done_idle_bus", LW'({bus.burst_read, bus.burst_write}), LW'(2'b00));
    if (wr) begin
      mem[al] = wl;
      cnt_wr++;
    end else begin
      mem[al] = exp_line;
      last_rd = exp_line;
      cnt_rd++;
    end
    chk("pmem_rdata", bus.pmem_rdata, last_rd);
  endtask

  task automatic idle();
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.burst_resp = 1'($urandom_range(1, 0));
    @(posedge clk); #1;
    chk("idle_pmem_resp", LW'(bus.pmem_resp), LW'(1'b0));
    chk("idle_bus", LW'({bus.burst_read, bus.burst_write}), LW'(2'b00));
    bus.burst_resp = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] dl;
    rst = 1'b1;
    bus.pmem_address = 32'd0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    last_rd          = '0;
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_rdata", bus.pmem_rdata, '0);
    chk("rst_outputs", LW'({bus.pmem_resp, bus.burst_read, bus.burst_write}), LW'(3'b000));
    chk("rst_burst_address", LW'(bus.burst_address), LW'(32'd0));
    chk("rst_burst_wdata", LW'(bus.burst_wdata), LW'(64'd0));
    rst = 1'b0;
    idle();

    // Zero-wait read with known beats
    mem[32'h0000_1220] = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    xfer(1'b0, 1'b0, 32'h0000_1234, '0, 0, 0, 1'b0);
    idle();

    // Write with two stall cycles per beat, then allocate read of the same line
    dl = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    xfer(1'b1, 1'b0, 32'h0000_2040, dl, 2, 2, 1'b0);
    xfer(1'b0, 1'b0, 32'h0000_205C, '0, 0, 1, 1'b1);
    chk("alloc_readback", bus.pmem_rdata, dl);
    idle();

    // Simultaneous read and write: write wins
    xfer(1'b1, 1'b1, 32'h0000_3000, rnd_line(), 0, 1, 1'b0);
    idle();

    // Reset after two beats of a read abandons it
    bus.pmem_address = 32'h0000_5000;
    bus.pmem_read    = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.pmem_read  = 1'b0;
    bus.burst_resp = 1'b0;
    @(posedge clk); #1;
    chk("midrst_burst_read", LW'(bus.burst_read), LW'(1'b0));
    chk("midrst_pmem_resp", LW'(bus.pmem_resp), LW'(1'b0));
    chk("midrst_pmem_rdata", bus.pmem_rdata, '0);
    rst     = 1'b0;
    last_rd = '0;
    cnt_rd  = 0;
    cnt_wr  = 0;
    idle();
    xfer(1'b0, 1'b0, 32'h0000_5000, '0, 0, 0, 1'b0);
    idle();

    // Randomized traffic over a small set of lines, with random back-to-back chaining
    begin
      bit chain;
      chain = 1'b0;
      for (int t = 0; t < 24; t++) begin
        bit w;
        w = 1'($urandom_range(1, 0));
        xfer(w, 1'($urandom_range(1, 0)),
             32'h0000_4000 + 32'($urandom_range(3, 0) * 32) + 32'($urandom_range(31, 0)),
             rnd_line(), 0, 3, chain);
        chain = 1'($urandom_range(1, 0));
        if (!chain) idle();
      end
      if (chain) idle();
    end

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
    chk("line_reads", LW'(line_reads), LW'(32'(cnt_rd)));
    chk("line_writes", LW'(line_writes), LW'(32'(cnt_wr)));
    xfer(1'b0, 1'b0, 32'h0000_4000, '0, 0, 0, 1'b0);
    perf_clr = 1'b1;
    idle();
    perf_clr = 1'b0;
    chk("clr_line_reads", LW'(line_reads), LW'(32'd0));
    chk("clr_line_writes", LW'(line_writes), LW'(32'd0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
